mem_burst_initiator: RTL and testbench
======================================

Name: mem_burst_initiator

Overview:
- Initiator-side controller that drives the Memory256x16 port (addr, Data, WE, MemOut) on behalf of the multicycle RISC datapath or a loader.
- Accepts one burst request (read or write, 1-16 beats, start address), sequences the memory, and streams write data in or read data out.
- Sits between the control FSM / debug loader and Memory256x16. It is the only driver of the memory's addr/Data/WE.

Parameters:
- ADDR_W, 8, used address bits; the memory addr port is 16 bits and the upper bits are driven 0.
- DATA_W, 16, word width.
- RD_LAT, 1, clk cycles from addr registered at the memory port to MemOut valid (1..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  burst request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = write burst, 0 = read burst.
- req_addr  in  8  start word address.
- req_len  in  4  beats minus 1 (0 = 1 beat, 15 = 16 beats).
- wr_data  in  16  write beat data.
- wr_valid  in  1  write beat present.
- wr_ready  out  1  high in WRITE state.
- rd_data  out  16  read beat data, registered.
- rd_valid  out  1  one-cycle strobe per read beat; no backpressure.
- busy  out  1  high whenever not IDLE.
- done  out  1  one-cycle pulse when a burst completes.
- addr  out  16  to memory, registered, {8'h00, word address}.
- Data  out  16  to memory, registered.
- WE  out  1  to memory, registered, high for exactly one cycle per written beat.
- MemOut  in  16  from memory.

Behaviour:
- Reset (async, immediate): state IDLE. addr=0, Data=0, WE=0, rd_data=0, rd_valid=0, done=0, busy=0, beat counter=0, read pipeline cleared.
- Reset mid-burst: WE drops in the same instant. The burst is abandoned; no done, no further rd_valid.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_addr into cur_addr and req_len into beats_left.
  - Go to WRITE if req_we, else READ.
- WRITE:
  - wr_ready=1.
  - Each cycle with wr_valid: next edge registers addr=cur_addr, Data=wr_data, WE=1. cur_addr increments, beats_left decrements.
  - Cycles without wr_valid: WE=0 next cycle; stalls are unlimited.
  - After the beat where beats_left==0 is accepted, go to DONE. WE is 1 in that DONE cycle so the last write lands.
- READ:
  - Each cycle registers addr=cur_addr, WE=0, and pushes a token into an RD_LAT-deep valid shift register. cur_addr increments.
  - After issuing the beat with beats_left==0, go to DRAIN.
- DRAIN: wait until the shift register is empty, then go to DONE.
- Read return: a token reaching the pipeline end loads rd_data<=MemOut and sets rd_valid=1 next cycle. Beats return in address order.
- Read latency: with RD_LAT=1, first rd_valid is 2 cycles after the addr edge. Beats are back-to-back, one per cycle.
- DONE: done=1 for one cycle, WE=0, then IDLE. req_ready stays 0 during DONE.
- Address arithmetic: 8-bit wrap, 8'hFF+1 = 8'h00. No error is raised.
- A request arriving while busy is not accepted; the requester must hold req_valid.
- WE is never asserted outside WRITE and the following DONE cycle.
- WE and rd_valid are never both driven by the same burst.

Decomposition:
- Shared package mem_pkg: ADDR_W, DATA_W, MEM_DEPTH=256, state encoding constants for the five states.
- One natural sub-module: mem_rd_pipe, the RD_LAT-deep valid/token shift register with empty flag.

Test Plan:
- Single write then read: write req addr=8'h10, len=0, wr_data=16'hBEEF → one WE pulse with addr=16'h0010, Data=16'hBEEF, then done. Read req addr=8'h10, len=0 → one rd_valid with rd_data=16'hBEEF, then done.
- 4-beat write with stalls: addr=8'h20, len=3, data A1..A4, wr_valid deasserted 2 cycles between beats 2 and 3 → exactly 4 WE pulses at 0x20..0x23. A 4-beat read returns A1..A4 on 4 consecutive rd_valid cycles.
- Wrap-around: 16-beat write at 8'hF8 with data=address → writes to 0xF8..0xFF then 0x00..0x07. Readback of 8'h00, len=7 returns 16'h0000..16'h0007.
- Back-to-back requests: req_valid held continuously with a second read queued → second request accepted only on the cycle after done (req_ready=1). No overlap of busy between bursts.
- Reset mid-write: rst asserted after beat 2 of a 4-beat write at 8'h40 → WE=0 immediately, no done. Readback shows 0x40/0x41 written and 0x42/0x43 unchanged.
- RD_LAT=3 build: 4-beat read → first rd_valid 4 cycles after the first addr edge, data in order, done after the last beat.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths, memory geometry and controller state encoding for the
// Memory256x16 burst initiator.
package mem_pkg;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned MEM_DEPTH  = 256;
  localparam int unsigned MEM_ADDR_W = 16;
  localparam int unsigned LEN_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Word address increment; wraps 8'hFF -> 8'h00 silently.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-token shift register that tracks outstanding memory reads; the token
// leaving the last stage marks the cycle MemOut holds that beat's data.
module mem_rd_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  output logic pop,
  output logic empty_c
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  always_comb begin
    valid_d = (valid_q << 1) | DEPTH'(push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign pop     = valid_q[DEPTH-1];
  assign empty_c = ~|valid_q;

endmodule

// File: rtl/mem_burst_initiator.sv
// Burst controller that is the sole driver of the Memory256x16 port: streams
// write beats in, issues read addresses and returns read data in order.
module mem_burst_initiator
  import mem_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [LEN_W-1:0]      req_len,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic [MEM_ADDR_W-1:0] addr,
  output logic [DATA_W-1:0]     Data,
  output logic                  WE,
  input  logic [DATA_W-1:0]     MemOut
);

  localparam int unsigned PAD_W = MEM_ADDR_W - ADDR_W;

  state_e              state_q,      state_d;
  logic [ADDR_W-1:0]   cur_addr_q,   cur_addr_d;
  logic [LEN_W-1:0]    beats_left_q, beats_left_d;
  logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0]   data_q,       data_d;
  logic                we_q,         we_d;
  logic                rd_issue_q,   rd_issue_d;
  logic [DATA_W-1:0]   rd_data_q,    rd_data_d;
  logic                rd_valid_q,   rd_valid_d;
  logic                done_q,       done_d;
  logic                busy_q,       busy_d;
  logic                req_ready_q,  req_ready_d;
  logic                wr_ready_q,   wr_ready_d;

  logic                pipe_pop;
  logic                pipe_empty_c;

  // rd_issue_q marks the cycle an address sits at the memory port; the
  // pipe then counts RD_LAT cycles until MemOut holds that beat.
  mem_rd_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .push    (rd_issue_q),
    .pop     (pipe_pop),
    .empty_c (pipe_empty_c)
  );

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    mem_addr_d   = mem_addr_q;
    data_d       = data_q;
    we_d         = 1'b0;
    rd_issue_d   = 1'b0;
    rd_valid_d   = pipe_pop;
    rd_data_d    = pipe_pop ? MemOut : rd_data_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cur_addr_d   = req_addr;
          beats_left_d = req_len;
          state_d      = req_we ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (wr_valid) begin
          mem_addr_d   = cur_addr_q;
          data_d       = wr_data;
          we_d         = 1'b1;
          cur_addr_d   = addr_inc(cur_addr_q);
          beats_left_d = beats_left_q - LEN_W'(1);
          if (beats_left_q == '0) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_READ: begin
        mem_addr_d   = cur_addr_q;
        rd_issue_d   = 1'b1;
        cur_addr_d   = addr_inc(cur_addr_q);
        beats_left_d = beats_left_q - LEN_W'(1);
        if (beats_left_q == '0) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty_c && !rd_issue_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered against the next state so they line up
    // with the state they describe.
    done_d      = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
    req_ready_d = (state_d == ST_IDLE);
    wr_ready_d  = (state_d == ST_WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      mem_addr_q   <= '0;
      data_q       <= '0;
      we_q         <= 1'b0;
      rd_issue_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      req_ready_q  <= 1'b1;
      wr_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      mem_addr_q   <= mem_addr_d;
      data_q       <= data_d;
      we_q         <= we_d;
      rd_issue_q   <= rd_issue_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      req_ready_q  <= req_ready_d;
      wr_ready_q   <= wr_ready_d;
    end
  end

  assign addr      = {{PAD_W{1'b0}}, mem_addr_q};
  assign Data      = data_q;
  assign WE        = we_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign req_ready = req_ready_q;
  assign wr_ready  = wr_ready_q;

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Directed bench for mem_burst_initiator: RD_LAT=1 and RD_LAT=3 instances,
// each attached to a behavioural Memory256x16 model.
module tb_mem_burst_initiator;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid, req_ready, req_we, wr_valid, wr_ready;
  logic [7:0]  req_addr;
  logic [3:0]  req_len;
  logic [15:0] wr_data, rd_data, addr, Data, MemOut;
  logic        rd_valid, busy, done, WE;

  logic        req_valid3, req_ready3, req_we3, wr_valid3, wr_ready3;
  logic [7:0]  req_addr3;
  logic [3:0]  req_len3;
  logic [15:0] wr_data3, rd_data3, addr3, Data3, MemOut3;
  logic        rd_valid3, busy3, done3, WE3;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_burst_initiator #(.RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .addr(addr), .Data(Data), .WE(WE), .MemOut(MemOut)
  );

  mem_burst_initiator #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(req_we3), .req_addr(req_addr3), .req_len(req_len3),
    .wr_data(wr_data3), .wr_valid(wr_valid3), .wr_ready(wr_ready3),
    .rd_data(rd_data3), .rd_valid(rd_valid3), .busy(busy3), .done(done3),
    .addr(addr3), .Data(Data3), .WE(WE3), .MemOut(MemOut3)
  );

  // Memory models: synchronous read sampled one edge after the address,
  // plus extra output stages for the RD_LAT=3 instance.
  logic [15:0] mem1 [256];
  logic [15:0] mem3 [256];
  logic [15:0] mo1, m3a, m3b, m3c;
  bit          mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] = 16'hC000 | 16'(i);
        mem3[i] = 16'h3000 | 16'(i);
      end
      mem_init_done = 1'b1;
    end
    mo1 <= mem1[addr[7:0]];
    m3a <= mem3[addr3[7:0]];
    m3b <= m3a;
    m3c <= m3b;
    if (WE)  mem1[addr[7:0]]  = Data;
    if (WE3) mem3[addr3[7:0]] = Data3;
  end
  assign MemOut  = mo1;
  assign MemOut3 = m3c;

  // Event logs, sampled mid-cycle.
  logic [15:0] we_addr_a [256];
  logic [15:0] we_data_a [256];
  logic [15:0] rd_a  [256];
  int          rd_c  [256];
  logic [15:0] rd3_a [256];
  int          rd3_c [256];
  int we_n = 0, rd_n = 0, done_n = 0, done_c = 0;
  int rd3_n = 0, done3_n = 0, done3_c = 0;

  always @(negedge clk) begin
    if (WE) begin
      we_addr_a[we_n % 256] <= addr;
      we_data_a[we_n % 256] <= Data;
      we_n <= we_n + 1;
    end
    if (rd_valid) begin
      rd_a[rd_n % 256] <= rd_data;
      rd_c[rd_n % 256] <= cyc;
      rd_n <= rd_n + 1;
    end
    if (done) begin
      done_n <= done_n + 1;
      done_c <= cyc;
    end
    if (rd_valid3) begin
      rd3_a[rd3_n % 256] <= rd_data3;
      rd3_c[rd3_n % 256] <= cyc;
      rd3_n <= rd3_n + 1;
    end
    if (done3) begin
      done3_n <= done3_n + 1;
      done3_c <= cyc;
    end
  end

  // Drivers (stimulus only).
  task automatic start_req(input logic we, input logic [7:0] a, input logic [3:0] len,
                           output bit ok, output int t);
    req_we = we; req_addr = a; req_len = len; req_valid = 1'b1;
    ok = 1'b0; t = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy) begin ok = 1'b1; t = cyc; break; end
    end
    req_valid = 1'b0;
  endtask

  task automatic feed_write(input logic [15:0] d [16], input int n,
                            input int stall_at, input int stall_n);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        wr_valid = 1'b0;
        repeat (stall_n) @(negedge clk);
      end
      wr_data = d[i]; wr_valid = 1'b1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_addr = 0; req_len = 0; wr_data = 0; wr_valid = 0;
    req_valid3 = 0; req_we3 = 0; req_addr3 = 0; req_len3 = 0; wr_data3 = 0; wr_valid3 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req_ready, wr_ready, busy, done, WE, rd_valid} !== 6'b100000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 100000", {req_ready, wr_ready, busy, done, WE, rd_valid});
    end
    n_checks++;
    if ({addr, Data, rd_data} !== 48'h0) begin
      n_errors++;
      $display("FAIL reset_regs: got %h expected 0", {addr, Data, rd_data});
    end
    n_checks++;
    if ({req_ready3, busy3, WE3, rd_valid3, done3} !== 5'b10000) begin
      n_errors++;
      $display("FAIL reset_lat3: got %b expected 10000", {req_ready3, busy3, WE3, rd_valid3, done3});
    end
  endtask

  task automatic test_single;
    logic [15:0] d [16];
    bit ok; int t, wb, rb, db;
    d = '{default: 16'h0}; d[0] = 16'hBEEF;
    wb = we_n; db = done_n;
    start_req(1'b1, 8'h10, 4'd0, ok, t);
    n_checks++;
    if (!ok || wr_ready !== 1'b1) begin
      n_errors++; $display("FAIL single_wr_accept: got ok=%0d wr_ready=%b expected 1/1", ok, wr_ready);
    end
    feed_write(d, 1, -1, 0);
    wait_done(10, ok);
    n_checks++;
    if (!ok || we_n - wb != 1 || done_n - db != 1) begin
      n_errors++; $display("FAIL single_wr_pulses: got done_ok=%0d we=%0d done=%0d expected 1/1/1", ok, we_n - wb, done_n - db);
    end
    n_checks++;
    if (we_addr_a[wb % 256] !== 16'h0010 || we_data_a[wb % 256] !== 16'hBEEF) begin
      n_errors++; $display("FAIL single_wr_beat: got %h/%h expected 0010/beef", we_addr_a[wb % 256], we_data_a[wb % 256]);
    end
    wb = we_n; rb = rd_n;
    start_req(1'b0, 8'h10, 4'd0, ok, t);
    wait_done(20, ok);
    n_checks++;
    if (!ok || rd_n - rb != 1 || rd_a[rb % 256] !== 16'hBEEF) begin
      n_errors++; $display("FAIL single_rd_data: got ok=%0d n=%0d data=%h expected 1/1/beef", ok, rd_n - rb, rd_a[rb % 256]);
    end
    n_checks++;
    if (rd_c[rb % 256] != t + 3 || done_c != rd_c[rb % 256] + 1) begin
      n_errors++; $display("FAIL single_rd_timing: got rd=%0d done=%0d expected %0d/%0d", rd_c[rb % 256], done_c, t + 3, t + 4);
    end
    n_checks++;
    if (we_n != wb) begin
      n_errors++; $display("FAIL single_rd_no_we: got %0d expected 0", we_n - wb);
    end
  endtask

  task automatic test_burst_stall;
    logic [15:0] d [16];
    bit ok; int t, wb, rb;
    d = '{default: 16'h0};
    for (int i = 0; i < 4; i++) d[i] = 16'h00A1 + 16'(i);
    wb = we_n;
    start_req(1'b1, 8'h20, 4'd3, ok, t);
    feed_write(d, 4, 2, 2);
    wait_done(10, ok);
    n_checks++;
    if (!ok || we_n - wb != 4) begin
      n_errors++; $display("FAIL stall_we_count: got ok=%0d n=%0d expected 1/4", ok, we_n - wb);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (we_addr_a[(wb + i) % 256] !== 16'h0020 + 16'(i) || we_data_a[(wb + i) % 256] !== 16'h00A1 + 16'(i)) begin
        n_errors++; $display("FAIL stall_we_beat%0d: got %h/%h expected %h/%h", i,
          we_addr_a[(wb + i) % 256], we_data_a[(wb + i) % 256], 16'h0020 + 16'(i), 16'h00A1 + 16'(i));
      end
    end
    rb = rd_n;
    start_req(1'b0, 8'h20, 4'd3, ok, t);
    wait_done(30, ok);
    n_checks++;
    if (!ok || rd_n - rb != 4) begin
      n_errors++; $display("FAIL stall_rd_count: got ok=%0d n=%0d expected 1/4", ok, rd_n - rb);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd_a[(rb + i) % 256] !== 16'h00A1 + 16'(i) || rd_c[(rb + i) % 256] != t + 3 + i) begin
        n_errors++; $display("FAIL stall_rd_beat%0d: got %h@%0d expected %h@%0d", i,
          rd_a[(rb + i) % 256], rd_c[(rb + i) % 256], 16'h00A1 + 16'(i), t + 3 + i);
      end
    end
  endtask

  task automatic test_wrap;
    logic [15:0] d [16];
    logic [7:0] a;
    bit ok; int t, wb, rb;
    for (int i = 0; i < 16; i++) begin
      a = 8'hF8 + 8'(i);
      d[i] = {8'h00, a};
    end
    wb = we_n;
    start_req(1'b1, 8'hF8, 4'd15, ok, t);
    feed_write(d, 16, -1, 0);
    wait_done(10, ok);
    n_checks++;
    if (!ok || we_n - wb != 16) begin
      n_errors++; $display("FAIL wrap_we_count: got ok=%0d n=%0d expected 1/16", ok, we_n - wb);
    end
    for (int i = 0; i < 16; i++) begin
      a = 8'hF8 + 8'(i);
      n_checks++;
      if (we_addr_a[(wb + i) % 256] !== {8'h00, a} || we_data_a[(wb + i) % 256] !== {8'h00, a}) begin
        n_errors++; $display("FAIL wrap_we_beat%0d: got %h/%h expected %h", i,
          we_addr_a[(wb + i) % 256], we_data_a[(wb + i) % 256], {8'h00, a});
      end
    end
    rb = rd_n;
    start_req(1'b0, 8'h00, 4'd7, ok, t);
    wait_done(30, ok);
    n_checks++;
    if (!ok || rd_n - rb != 8) begin
      n_errors++; $display("FAIL wrap_rd_count: got ok=%0d n=%0d expected 1/8", ok, rd_n - rb);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rd_a[(rb + i) % 256] !== 16'(i)) begin
        n_errors++; $display("FAIL wrap_rd_beat%0d: got %h expected %h", i, rd_a[(rb + i) % 256], 16'(i));
      end
    end
  endtask

  task automatic test_back_to_back;
    int cd, ca2, overlap, phase, rb;
    bit rr_after, ok;
    cd = -1; ca2 = -1; overlap = 0; phase = 0; rr_after = 1'b0;
    rb = rd_n;
    req_we = 1'b0; req_addr = 8'h20; req_len = 4'd1; req_valid = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (busy && req_ready) overlap++;
      if (phase == 0 && busy) begin
        req_addr = 8'h10; req_len = 4'd0; phase = 1;
      end else if (phase == 1 && done) begin
        cd = cyc; phase = 2;
      end else if (phase == 2) begin
        if (cyc == cd + 1) rr_after = req_ready && !busy;
        if (busy) begin ca2 = cyc; req_valid = 1'b0; break; end
      end
    end
    req_valid = 1'b0;
    n_checks++;
    if (!rr_after || ca2 != cd + 2 || overlap != 0) begin
      n_errors++; $display("FAIL b2b_handoff: got idle_ready=%0d accept=%0d done=%0d overlap=%0d expected 1/%0d/-/0",
        rr_after, ca2, cd, overlap, cd + 2);
    end
    wait_done(30, ok);
    n_checks++;
    if (!ok || rd_n - rb != 3 || rd_a[rb % 256] !== 16'h00A1 || rd_a[(rb + 1) % 256] !== 16'h00A2 ||
        rd_a[(rb + 2) % 256] !== 16'hBEEF) begin
      n_errors++; $display("FAIL b2b_data: got n=%0d %h %h %h expected 3 00a1 00a2 beef",
        rd_n - rb, rd_a[rb % 256], rd_a[(rb + 1) % 256], rd_a[(rb + 2) % 256]);
    end
  endtask

  task automatic test_reset_mid_write;
    bit ok; int t, db, rb;
    start_req(1'b1, 8'h40, 4'd3, ok, t);
    wr_valid = 1'b1; wr_data = 16'h1234; @(negedge clk);
    wr_data = 16'h5678; @(negedge clk);
    wr_data = 16'h9ABC; @(negedge clk);
    #2 rst = 1'b1;
    db = done_n;
    #1;
    n_checks++;
    if ({WE, busy, done} !== 3'b000) begin
      n_errors++; $display("FAIL rst_mid_async: got WE/busy/done=%b expected 000", {WE, busy, done});
    end
    wr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_n != db || busy !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid_no_done: got done_pulses=%0d busy=%b expected 0/0", done_n - db, busy);
    end
    rb = rd_n;
    start_req(1'b0, 8'h40, 4'd3, ok, t);
    wait_done(30, ok);
    n_checks++;
    if (!ok || rd_n - rb != 4 || rd_a[rb % 256] !== 16'h1234 || rd_a[(rb + 1) % 256] !== 16'h5678 ||
        rd_a[(rb + 2) % 256] !== 16'hC042 || rd_a[(rb + 3) % 256] !== 16'hC043) begin
      n_errors++; $display("FAIL rst_mid_readback: got n=%0d %h %h %h %h expected 4 1234 5678 c042 c043",
        rd_n - rb, rd_a[rb % 256], rd_a[(rb + 1) % 256], rd_a[(rb + 2) % 256], rd_a[(rb + 3) % 256]);
    end
  endtask

  task automatic test_lat3;
    int ca, rb, db;
    bit ok;
    ca = -1; ok = 1'b0; rb = rd3_n; db = done3_n;
    req_we3 = 1'b0; req_addr3 = 8'h80; req_len3 = 4'd3; req_valid3 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy3) begin ca = cyc; break; end
    end
    req_valid3 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done3) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    n_checks++;
    if (!ok || ca < 0 || rd3_n - rb != 4 || done3_n - db != 1) begin
      n_errors++; $display("FAIL lat3_count: got ok=%0d beats=%0d done=%0d expected 1/4/1", ok, rd3_n - rb, done3_n - db);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd3_a[(rb + i) % 256] !== 16'h3080 + 16'(i) || rd3_c[(rb + i) % 256] != ca + 5 + i) begin
        n_errors++; $display("FAIL lat3_beat%0d: got %h@%0d expected %h@%0d", i,
          rd3_a[(rb + i) % 256], rd3_c[(rb + i) % 256], 16'h3080 + 16'(i), ca + 5 + i);
      end
    end
    n_checks++;
    if (done3_c != ca + 9) begin
      n_errors++; $display("FAIL lat3_done: got %0d expected %0d", done3_c, ca + 9);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid_write();
    test_lat3();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
